// File: rtl/riscv_pc_pkg.sv
// Shared definitions for the fetch PC / branch prediction stage.
// Holds ALU codes for jumps, 2-bit counter encodings, BTB entry layout and the counter update rule.
// No ports; pure type/constant package.
package riscv_pc_pkg;

    localparam logic [4:0] ALU_JAL  = 5'b01010;
    localparam logic [4:0] ALU_JALR = 5'b01011;

    // Widest PC the BTB entry layout can hold; narrower builds leave the
    // upper bits constant zero.
    localparam int BTB_MAX_ADDR_WIDTH = 64;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bp_counter_t;

    typedef logic [BTB_MAX_ADDR_WIDTH-1:0] btb_field_t;

    typedef struct packed {
        logic        valid;
        btb_field_t  tag;
        btb_field_t  target;
        bp_counter_t counter;
    } btb_entry_t;

    // Saturating 2-bit counter step towards the resolved direction.
    function automatic bp_counter_t counter_update(input bp_counter_t c, input logic taken);
        bp_counter_t r;
        if (taken) begin
            r = (c == STRONG_T) ? STRONG_T : bp_counter_t'(c + 2'd1);
        end else begin
            r = (c == STRONG_NT) ? STRONG_NT : bp_counter_t'(c - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating counters.
// Latency: lookup combinational on lookup_pc; update written at the rising edge, visible the next cycle.
// Backpressure: none; the caller gates upd_en (a lookup racing a write to the same index sees the old entry).
//
// Ports: clk/rst_n (async active-low), lookup_pc -> predict_taken/predict_target,
//        upd_en/upd_pc/upd_taken/upd_target single synchronous update port.
module branch_target_buffer
    import riscv_pc_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  predict_taken,
    output logic [ADDR_WIDTH-1:0] predict_target,
    input  logic                  upd_en,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

    btb_entry_t entries [DEPTH];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    btb_entry_t       lk_entry;
    btb_entry_t       up_entry;
    btb_entry_t       up_next;
    logic             lk_hit;
    logic             up_hit;
    logic             up_we;
    logic             unused_pc_lsbs;

    // Instructions are word aligned, so the low two PC bits carry no information.
    assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[ADDR_WIDTH-1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[ADDR_WIDTH-1:IDX_W+2];

    assign lk_entry = entries[lk_idx];
    assign up_entry = entries[up_idx];

    assign lk_hit         = lk_entry.valid && (lk_entry.tag == btb_field_t'(lk_tag));
    assign predict_taken  = lk_hit && (lk_entry.counter >= WEAK_T);
    assign predict_target = ADDR_WIDTH'(lk_entry.target);

    assign up_hit = up_entry.valid && (up_entry.tag == btb_field_t'(up_tag));

    always_comb begin
        up_next = up_entry;
        up_we   = 1'b0;
        if (upd_en) begin
            if (up_hit) begin
                up_we           = 1'b1;
                up_next.counter = counter_update(up_entry.counter, upd_taken);
                if (upd_taken) begin
                    up_next.target = btb_field_t'(upd_target);
                end
            end else if (upd_taken) begin
                // Taken miss claims the slot regardless of what lived there.
                up_we           = 1'b1;
                up_next.valid   = 1'b1;
                up_next.tag     = btb_field_t'(up_tag);
                up_next.target  = btb_field_t'(upd_target);
                up_next.counter = WEAK_T;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '{valid: 1'b0, tag: '0, target: '0, counter: WEAK_NT};
            end
        end else if (up_we) begin
            entries[up_idx] <= up_next;
        end
    end

endmodule

// File: rtl/pc_predict_stage.sv
// Fetch PC register with BTB prediction and execute-stage redirect/flush.
// Latency: CLEAR_* and PREDICT_TAKEN combinational; redirected PC appears one edge after the mispredict.
// Backpressure: STALL_EXECUTION_STAGE holds the PC and suppresses resolution (no BTB update, no flush).
//
// Optional BTB selected by macro PC_BTB_EN; without it PREDICT_TAKEN is 0 and fetch is purely sequential.
// Ports: CLK, RST_N (async active-low); execute-side resolution inputs (STALL_EXECUTION_STAGE,
//        VALID_EXECUTION, BRANCH_EXECUTION, ALU_INSTRUCTION, BRANCH_TAKEN, PC_EXECUTION, RS1_DATA,
//        IMM_INPUT), PC_DECODING; outputs PC, PREDICT_TAKEN, CLEAR_DECODING_STAGE, CLEAR_EXECUTION_STAGE.
module pc_predict_stage #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    BTB_DEPTH    = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [4:0]            ALU_JAL      = riscv_pc_pkg::ALU_JAL,
    parameter logic [4:0]            ALU_JALR     = riscv_pc_pkg::ALU_JALR
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  STALL_EXECUTION_STAGE,
    input  logic                  VALID_EXECUTION,
    input  logic                  BRANCH_EXECUTION,
    input  logic [4:0]            ALU_INSTRUCTION,
    input  logic                  BRANCH_TAKEN,
    input  logic [ADDR_WIDTH-1:0] PC_EXECUTION,
    input  logic [ADDR_WIDTH-1:0] RS1_DATA,
    input  logic [ADDR_WIDTH-1:0] IMM_INPUT,
    input  logic [ADDR_WIDTH-1:0] PC_DECODING,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic                  PREDICT_TAKEN,
    output logic                  CLEAR_DECODING_STAGE,
    output logic                  CLEAR_EXECUTION_STAGE
);

    localparam logic [ADDR_WIDTH-1:0] INSN_BYTES = ADDR_WIDTH'(4);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  is_jal;
    logic                  is_jalr;
    logic                  resolve;
    logic                  taken;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic [ADDR_WIDTH-1:0] jalr_sum;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] actual_next;
    logic                  mispredict;
    logic                  btb_predict;
    logic [ADDR_WIDTH-1:0] btb_target;

    // ---------------- execute-side resolution ----------------
    assign is_jal  = (ALU_INSTRUCTION == ALU_JAL);
    assign is_jalr = (ALU_INSTRUCTION == ALU_JALR);

    assign resolve = VALID_EXECUTION && !STALL_EXECUTION_STAGE
                   && (BRANCH_EXECUTION || is_jal || is_jalr);
    assign taken   = is_jal || is_jalr || (BRANCH_EXECUTION && BRANCH_TAKEN);

    assign branch_target = PC_EXECUTION + IMM_INPUT;
    assign jalr_sum      = RS1_DATA + IMM_INPUT;
    assign target        = is_jalr ? {jalr_sum[ADDR_WIDTH-1:1], 1'b0} : branch_target;
    assign actual_next   = taken ? target : (PC_EXECUTION + INSN_BYTES);

    // Decode already holds whatever fetch guessed; any disagreement means both
    // younger stages hold wrong-path instructions.
    assign mispredict = resolve && (actual_next != PC_DECODING);

    // ---------------- prediction ----------------
`ifdef PC_BTB_EN
    branch_target_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (BTB_DEPTH)
    ) u_btb (
        .clk            (CLK),
        .rst_n          (RST_N),
        .lookup_pc      (pc_q),
        .predict_taken  (btb_predict),
        .predict_target (btb_target),
        .upd_en         (resolve),
        .upd_pc         (PC_EXECUTION),
        .upd_taken      (taken),
        .upd_target     (target)
    );
`else
    assign btb_predict = 1'b0;
    assign btb_target  = '0;
`endif

    // ---------------- next PC ----------------
    always_comb begin
        pc_next = pc_q + INSN_BYTES;
        if (mispredict) begin
            pc_next = actual_next;
        end else if (STALL_EXECUTION_STAGE) begin
            pc_next = pc_q;
        end else if (btb_predict) begin
            pc_next = btb_target;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_next;
        end
    end

    // Outputs are masked during reset so a stale execute stage cannot flush
    // or steer anything while the pipeline is being reset.
    assign PC                    = pc_q;
    assign PREDICT_TAKEN         = btb_predict && RST_N;
    assign CLEAR_DECODING_STAGE  = mispredict && RST_N;
    assign CLEAR_EXECUTION_STAGE = mispredict && RST_N;

endmodule

// File: doc/pc_predict_stage.md
# pc_predict_stage

Parametrised program-counter stage for the RISC-V pipeline. Holds the fetch PC and produces the next PC from sequential increment, a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, or an execution-stage redirect. Compares each resolved control transfer in execute against the PC already in decode, and flushes decode/execute on mismatch. Sits between instruction fetch and the execution stage's branch/jump resolution.

## Interface
- ADDR_WIDTH, 32, PC width in bits; ≥ 16.
- BTB_DEPTH, 16, BTB entries; power of two, 2..256.
- RESET_VECTOR, 32'h0000_0000, PC value loaded at reset.
- ALU_JAL, 5'b01010, ALU code for JAL.
- ALU_JALR, 5'b01011, ALU code for JALR.
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- STALL_EXECUTION_STAGE  in  1  execute instruction not advancing this cycle.
- VALID_EXECUTION  in  1  execute holds a real (non-bubble) instruction.
- BRANCH_EXECUTION  in  1  execute instruction is a conditional branch.
- ALU_INSTRUCTION  in  5  ALU code of the execute instruction.
- BRANCH_TAKEN  in  1  branch condition result in execute.
- PC_EXECUTION  in  ADDR_WIDTH  PC of the execute instruction.
- RS1_DATA  in  ADDR_WIDTH  rs1 operand, used by JALR.
- IMM_INPUT  in  ADDR_WIDTH  sign-extended immediate.
- PC_DECODING  in  ADDR_WIDTH  PC of the instruction currently in decode.
- PC  out  ADDR_WIDTH  current fetch PC.
- PREDICT_TAKEN  out  1  BTB predicts a taken transfer at PC.
- CLEAR_DECODING_STAGE  out  1  flush decode.
- CLEAR_EXECUTION_STAGE  out  1  flush execute.

## Operation
- resolve = VALID_EXECUTION & !STALL_EXECUTION_STAGE & (BRANCH_EXECUTION | JAL | JALR).
- Taken = JAL | JALR | (BRANCH_EXECUTION & BRANCH_TAKEN).
- Target: JAL/branch = PC_EXECUTION + IMM_INPUT. JALR = (RS1_DATA + IMM_INPUT) with bit 0 cleared. Sums wrap modulo 2^ADDR_WIDTH.
- Actual next = Taken ? target : PC_EXECUTION + 4.
- mispredict = resolve & (actual next != PC_DECODING). CLEAR_DECODING_STAGE = CLEAR_EXECUTION_STAGE = mispredict.
- Next-PC priority:
  1. mispredict → actual next.
  2. STALL_EXECUTION_STAGE → hold PC.
  3. PREDICT_TAKEN → BTB target.
  4. Otherwise → PC + 4.
- BTB lookup (combinational on PC):
  - index = PC[log2(BTB_DEPTH)+1:2]; tag = PC[ADDR_WIDTH-1:log2(BTB_DEPTH)+2].
  - PREDICT_TAKEN = valid & tag match & counter[1].
- BTB update on resolve only:
  - Hit, taken: target rewritten; counter increments, saturating at 2'b11.
  - Hit, not taken: counter decrements, saturating at 2'b00.
  - Miss, taken: entry allocated (overwrite) with valid=1, counter 2'b10.
  - Miss, not taken: no change.
- A stalled or bubble execute instruction has no effect: no update, no flush.

## Timing
- Reset (RST_N low, async): PC = RESET_VECTOR; all BTB valid bits 0; all counters 2'b01. While RST_N is low, PREDICT_TAKEN and both CLEAR outputs are forced 0.
- CLEAR outputs and PREDICT_TAKEN are combinational in the same cycle as their cause. The redirected PC appears one edge after the mispredict cycle.
- A BTB write is visible to lookup from the cycle after the resolving edge. If a lookup and a write hit the same index in one cycle, the lookup returns the old entry.
- Mispredict penalty is 2 cycles (decode + execute flushed).
- Reset mid-operation discards all in-flight redirects and BTB contents.

## Configuration
- PC_BTB_EN defined: BTB and prediction are present as described.
- PC_BTB_EN undefined: no BTB storage; PREDICT_TAKEN tied 0; next PC is PC + 4 unless there is a mispredict or stall. Redirect and flush logic are unchanged, so every taken transfer mispredicts.

## Structure
- Shared package riscv_pc_pkg holds:
  - ALU_JAL/ALU_JALR constants.
  - Counter constants (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11).
  - BTB entry typedef (valid, tag, target, counter).
- One sub-module, branch_target_buffer:
  - Async-reset entry array.
  - Combinational lookup port and single synchronous update port.
  - Instantiated only under PC_BTB_EN.

## Test plan
- Reset: drive RST_N low mid-run with PC=0x40 → PC=0x0 immediately; PREDICT_TAKEN=0; after release, PC steps 0x0, 0x4, 0x8.
- JAL: PC_EXECUTION=0x100, IMM=0x20, PC_DECODING=0x104 → both CLEARs=1 that cycle; PC=0x120 next edge; BTB entry for 0x100 allocated. A later fetch at 0x100 gives PREDICT_TAKEN=1 and next PC 0x120.
- JALR: RS1=0x203, IMM=0x4, PC_DECODING=0x207 → target 0x206, mispredict, PC=0x206.
- Loop branch at 0x80 → 0x60: counter saturates 10→11 after two taken resolutions. Two not-taken resolutions take it 11→10→01, and PREDICT_TAKEN drops to 0.
- Correct prediction: taken branch with PC_DECODING equal to target → no CLEARs, PC advances normally.
- Stall: STALL_EXECUTION_STAGE=1 with a mispredicting branch in execute → PC held, no CLEAR, BTB unchanged. Releasing the stall produces the redirect on the next edge.
